// File: rtl/bsg_nasti_pkg.sv
// Shared NASTI packet types for the N:1 NASTI mux and its helpers.
//   bsg_nasti_a_pkt  AR/AW request
//   bsg_nasti_w_pkt  write data beat
//   bsg_nasti_b_pkt  write response
//   bsg_nasti_r_pkt  read data beat
// Also provides the w/r last-beat accessors, the W-channel FSM state type and
// a clog2 helper that never returns 0.
package bsg_nasti_pkg;

    typedef struct packed {
        logic [5:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } bsg_nasti_a_pkt;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
    } bsg_nasti_w_pkt;

    typedef struct packed {
        logic [5:0] id;
        logic [1:0] resp;
    } bsg_nasti_b_pkt;

    typedef struct packed {
        logic [5:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } bsg_nasti_r_pkt;

    typedef enum logic {
        W_IDLE  = 1'b0,
        W_BURST = 1'b1
    } bsg_nasti_w_state_e;

    function automatic logic w_last(input bsg_nasti_w_pkt w);
        return w.last;
    endfunction

    function automatic logic r_last(input bsg_nasti_r_pkt r);
        return r.last;
    endfunction

    // Width of an index into n entries; at least 1 bit so n == 1 still works.
    function automatic int safe_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bsg_nasti_mux_order_fifo.sv
// Order FIFO of client indices, used to route in-order responses back to the
// client that issued the matching request.
//   v_i/data_i/ready_o : push side (ready_o = not full)
//   v_o/data_o/yumi_i  : pop side  (v_o = not empty, yumi_i pops the head)
// Depth els_p need not be a power of two. Full is evaluated on the current
// count, so a push into a full FIFO is refused even if a pop happens in the
// same cycle.
module bsg_nasti_mux_order_fifo
    import bsg_nasti_pkg::*;
#(
    parameter int width_p = 1,
    parameter int els_p   = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    localparam int ptr_w_lp = safe_clog2(els_p);
    localparam int cnt_w_lp = $clog2(els_p + 1);

    logic [width_p-1:0]  mem_r [els_p];
    logic [ptr_w_lp-1:0] rd_ptr_r, wr_ptr_r;
    logic [cnt_w_lp-1:0] count_r;
    logic                push, pop;

    assign ready_o = (count_r != cnt_w_lp'(els_p));
    assign v_o     = (count_r != '0);
    assign data_o  = mem_r[rd_ptr_r];
    assign push    = v_i & ready_o;
    assign pop     = yumi_i & v_o;

    function automatic logic [ptr_w_lp-1:0] bump(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + ptr_w_lp'(1);
    endfunction

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push) wr_ptr_r <= bump(wr_ptr_r);
            if (pop)  rd_ptr_r <= bump(rd_ptr_r);
            if (push && !pop)      count_r <= count_r + cnt_w_lp'(1);
            else if (pop && !push) count_r <= count_r - cnt_w_lp'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_r[wr_ptr_r] <= data_i;
    end

endmodule

// File: rtl/bsg_nasti_mux_n.sv
// N-client to 1-master NASTI multiplexer.
//   clk_i, reset_i         : clock, synchronous active-high reset
//   client_nasti_ar/aw/w_* : N client request channels (valid/data/ready)
//   client_nasti_b/r_*     : N client response channels
//   master_nasti_ar/aw/w_* : single master request channels
//   master_nasti_b/r_*     : single master response channels
// AR and AW are round-robin arbitrated combinationally. Once an AW wins, the
// W channel is locked to that client until its last beat. R and B are routed
// back through order FIFOs of client indices (master responds in order).
// Optional: define BSG_NASTI_MUX_PERF_EN to add perf_ar_grants_o and
// perf_aw_grants_o, per-client saturating 32-bit grant counters.
module bsg_nasti_mux_n
    import bsg_nasti_pkg::*;
#(
    parameter  int num_clients_p     = 2,
    parameter  int max_outstanding_p = 4,
    localparam int lg_clients_lp     = safe_clog2(num_clients_p)
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,

    input  logic           [num_clients_p-1:0]   client_nasti_ar_valid_i,
    input  bsg_nasti_a_pkt [num_clients_p-1:0]   client_nasti_ar_data_i,
    output logic           [num_clients_p-1:0]   client_nasti_ar_ready_o,

    input  logic           [num_clients_p-1:0]   client_nasti_aw_valid_i,
    input  bsg_nasti_a_pkt [num_clients_p-1:0]   client_nasti_aw_data_i,
    output logic           [num_clients_p-1:0]   client_nasti_aw_ready_o,

    input  logic           [num_clients_p-1:0]   client_nasti_w_valid_i,
    input  bsg_nasti_w_pkt [num_clients_p-1:0]   client_nasti_w_data_i,
    output logic           [num_clients_p-1:0]   client_nasti_w_ready_o,

    output logic           [num_clients_p-1:0]   client_nasti_b_valid_o,
    output bsg_nasti_b_pkt [num_clients_p-1:0]   client_nasti_b_data_o,
    input  logic           [num_clients_p-1:0]   client_nasti_b_ready_i,

    output logic           [num_clients_p-1:0]   client_nasti_r_valid_o,
    output bsg_nasti_r_pkt [num_clients_p-1:0]   client_nasti_r_data_o,
    input  logic           [num_clients_p-1:0]   client_nasti_r_ready_i,

    output logic                                 master_nasti_ar_valid_o,
    output bsg_nasti_a_pkt                       master_nasti_ar_data_o,
    input  logic                                 master_nasti_ar_ready_i,

    output logic                                 master_nasti_aw_valid_o,
    output bsg_nasti_a_pkt                       master_nasti_aw_data_o,
    input  logic                                 master_nasti_aw_ready_i,

    output logic                                 master_nasti_w_valid_o,
    output bsg_nasti_w_pkt                       master_nasti_w_data_o,
    input  logic                                 master_nasti_w_ready_i,

    input  logic                                 master_nasti_b_valid_i,
    input  bsg_nasti_b_pkt                       master_nasti_b_data_i,
    output logic                                 master_nasti_b_ready_o,

    input  logic                                 master_nasti_r_valid_i,
    input  bsg_nasti_r_pkt                       master_nasti_r_data_i,
    output logic                                 master_nasti_r_ready_o
`ifdef BSG_NASTI_MUX_PERF_EN
    ,
    output logic [num_clients_p-1:0][31:0]       perf_ar_grants_o,
    output logic [num_clients_p-1:0][31:0]       perf_aw_grants_o
`endif
);

    localparam int lg_w = lg_clients_lp;

    // First valid client at or after start, scanning upward with wrap.
    // Iterating from the farthest offset down lets the nearest one win.
    function automatic logic [lg_w-1:0] rr_pick(input logic [num_clients_p-1:0] v,
                                                 input logic [lg_w-1:0] start);
        logic [lg_w-1:0] pick;
        int idx;
        pick = start;
        for (int k = num_clients_p - 1; k >= 0; k--) begin
            idx = int'(start) + k;
            if (idx >= num_clients_p) idx = idx - num_clients_p;
            if (v[idx]) pick = lg_w'(idx);
        end
        return pick;
    endfunction

    function automatic logic [lg_w-1:0] next_idx(input logic [lg_w-1:0] i);
        return (int'(i) == num_clients_p - 1) ? '0 : i + lg_w'(1);
    endfunction

    logic               run;
    logic [lg_w-1:0]    ar_ptr_r, aw_ptr_r, ar_grant, aw_grant, w_owner_r;
    logic [lg_w-1:0]    rd_head, wr_head;
    logic               rd_ready, rd_v, wr_ready, wr_v;
    logic               ar_hs, aw_hs, w_hs, r_pop, b_pop;
    logic               w_in_burst;
    bsg_nasti_w_state_e w_state_r;

    // Holding every valid/ready low during reset keeps handshakes out of the
    // reset cycle regardless of stale state.
    assign run = ~reset_i;

    // ---------------- AR ----------------
    assign ar_grant                = rr_pick(client_nasti_ar_valid_i, ar_ptr_r);
    assign master_nasti_ar_valid_o = run & (|client_nasti_ar_valid_i) & rd_ready;
    assign master_nasti_ar_data_o  = client_nasti_ar_data_i[ar_grant];
    assign ar_hs                   = master_nasti_ar_valid_o & master_nasti_ar_ready_i;

    // ---------------- AW ----------------
    assign aw_grant                = rr_pick(client_nasti_aw_valid_i, aw_ptr_r);
    assign master_nasti_aw_valid_o = run & (w_state_r == W_IDLE)
                                   & (|client_nasti_aw_valid_i) & wr_ready;
    assign master_nasti_aw_data_o  = client_nasti_aw_data_i[aw_grant];
    assign aw_hs                   = master_nasti_aw_valid_o & master_nasti_aw_ready_i;

    // ---------------- W -----------------
    assign w_in_burst             = run & (w_state_r == W_BURST);
    assign master_nasti_w_valid_o = w_in_burst & client_nasti_w_valid_i[w_owner_r];
    assign master_nasti_w_data_o  = client_nasti_w_data_i[w_owner_r];
    assign w_hs                   = master_nasti_w_valid_o & master_nasti_w_ready_i;

    // ------------- R / B routing ---------
    assign master_nasti_r_ready_o = run & rd_v & client_nasti_r_ready_i[rd_head];
    assign master_nasti_b_ready_o = run & wr_v & client_nasti_b_ready_i[wr_head];
    assign r_pop = master_nasti_r_valid_i & master_nasti_r_ready_o & r_last(master_nasti_r_data_i);
    assign b_pop = master_nasti_b_valid_i & master_nasti_b_ready_o;

    always_comb begin
        client_nasti_ar_ready_o = '0;
        client_nasti_aw_ready_o = '0;
        client_nasti_w_ready_o  = '0;
        client_nasti_r_valid_o  = '0;
        client_nasti_b_valid_o  = '0;
        client_nasti_ar_ready_o[ar_grant] = ar_hs;
        client_nasti_aw_ready_o[aw_grant] = aw_hs;
        client_nasti_w_ready_o[w_owner_r] = w_in_burst & master_nasti_w_ready_i;
        client_nasti_r_valid_o[rd_head]   = run & rd_v & master_nasti_r_valid_i;
        client_nasti_b_valid_o[wr_head]   = run & wr_v & master_nasti_b_valid_i;
        for (int i = 0; i < num_clients_p; i++) begin
            client_nasti_r_data_o[i] = master_nasti_r_data_i;
            client_nasti_b_data_o[i] = master_nasti_b_data_i;
        end
    end

    // Pointers advance only on handshake, so a stalled grant stays put.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ar_ptr_r  <= '0;
            aw_ptr_r  <= '0;
            w_owner_r <= '0;
            w_state_r <= W_IDLE;
        end else begin
            if (ar_hs) ar_ptr_r <= next_idx(ar_grant);
            case (w_state_r)
                W_IDLE: if (aw_hs) begin
                    aw_ptr_r  <= next_idx(aw_grant);
                    w_owner_r <= aw_grant;
                    w_state_r <= W_BURST;
                end
                W_BURST: if (w_hs && w_last(master_nasti_w_data_o)) w_state_r <= W_IDLE;
                default: w_state_r <= W_IDLE;
            endcase
        end
    end

    bsg_nasti_mux_order_fifo #(.width_p(lg_w), .els_p(max_outstanding_p)) rd_order (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (ar_hs),
        .data_i  (ar_grant),
        .ready_o (rd_ready),
        .v_o     (rd_v),
        .data_o  (rd_head),
        .yumi_i  (r_pop)
    );

    bsg_nasti_mux_order_fifo #(.width_p(lg_w), .els_p(max_outstanding_p)) wr_order (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (aw_hs),
        .data_i  (aw_grant),
        .ready_o (wr_ready),
        .v_o     (wr_v),
        .data_o  (wr_head),
        .yumi_i  (b_pop)
    );

`ifdef BSG_NASTI_MUX_PERF_EN
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            perf_ar_grants_o <= '0;
            perf_aw_grants_o <= '0;
        end else begin
            for (int i = 0; i < num_clients_p; i++) begin
                if (ar_hs && ar_grant == lg_w'(i) && perf_ar_grants_o[i] != 32'hFFFF_FFFF)
                    perf_ar_grants_o[i] <= perf_ar_grants_o[i] + 32'd1;
                if (aw_hs && aw_grant == lg_w'(i) && perf_aw_grants_o[i] != 32'hFFFF_FFFF)
                    perf_aw_grants_o[i] <= perf_aw_grants_o[i] + 32'd1;
            end
        end
    end
`endif

    // A response with no recorded requester means the master broke ordering.
    r_has_order: assert property (@(posedge clk_i) disable iff (reset_i)
                                  master_nasti_r_valid_i |-> rd_v);
    b_has_order: assert property (@(posedge clk_i) disable iff (reset_i)
                                  master_nasti_b_valid_i |-> wr_v);

endmodule
